// File: rtl/proj_mux_ctrl.sv
// proj_mux_ctrl: connects one of N_PROJ wrapped projects to the shared pads.
// A switch always breaks before it makes. The new project is then held in reset
// for RST_HOLD cycles before its outputs reach the pads.
// Optional feature: define PROJ_MUX_CTRL_RUN_CNT_EN to add the run_cycles output,
// which counts the cycles spent in RUN.
module proj_mux_ctrl #(
    parameter int N_PROJ   = 8,
    parameter int ADDR_W   = 4,
    parameter int RST_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel_valid,
    input  logic [ADDR_W-1:0]    sel_addr,
    output logic                 sel_ready,
    input  logic [17:0]          pad_iw,
    output logic [23:0]          pad_ow,
    output logic [N_PROJ-1:0]    proj_ena,
    output logic [17:0]          proj_iw,
    input  logic [24*N_PROJ-1:0] proj_ow,
    output logic [ADDR_W-1:0]    active_addr,
    output logic                 running
`ifdef PROJ_MUX_CTRL_RUN_CNT_EN
    ,
    output logic [15:0]          run_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // The counter counts down to zero, so the HOLD state lasts exactly RST_HOLD cycles.
    localparam logic [7:0]        HOLD_LOAD = 8'(RST_HOLD - 1);
    localparam logic [N_PROJ-1:0] ENA_ONE   = {{(N_PROJ-1){1'b0}}, 1'b1};

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [7:0]        hold_cnt_r, hold_cnt_nxt_s;
    logic              accept_s;
    logic              in_range_s;

    assign accept_s   = sel_valid && ((state_r == ST_OFF) || (state_r == ST_RUN));
    assign in_range_s = (32'(addr_r) < 32'(N_PROJ));

    // State, latched address and HOLD counter registers, with synchronous reset to OFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_OFF;
            addr_r     <= '0;
            hold_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    // Next-state logic. A request is accepted only in OFF or RUN, and a request is never queued.
    always_comb begin
        state_nxt_s    = state_r;
        addr_nxt_s     = addr_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            ST_OFF, ST_RUN: begin
                if (accept_s) begin
                    addr_nxt_s  = sel_addr;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (in_range_s) begin
                    state_nxt_s    = ST_HOLD;
                    hold_cnt_nxt_s = HOLD_LOAD;
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == 8'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r - 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
            end
        endcase
    end

    // Output decode. While rst is high, every output shows its OFF value.
    always_comb begin
        sel_ready   = 1'b1;
        proj_ena    = '0;
        pad_ow      = 24'h0;
        running     = 1'b0;
        proj_iw     = pad_iw;
        active_addr = '0;
        if (rst) begin
            sel_ready = 1'b1;
        end else begin
            active_addr = addr_r;
            sel_ready   = (state_r == ST_OFF) || (state_r == ST_RUN);
            running     = (state_r == ST_RUN);
            if (((state_r == ST_HOLD) || (state_r == ST_RUN)) && in_range_s) begin
                proj_ena = ENA_ONE << addr_r;
            end else begin
                proj_ena = '0;
            end
            if (state_r == ST_HOLD) begin
                proj_iw[1] = 1'b0;
            end else begin
                proj_iw[1] = pad_iw[1];
            end
            if (state_r == ST_RUN) begin
                for (int k = 0; k < N_PROJ; k++) begin
                    pad_ow = pad_ow | (proj_ow[k*24 +: 24] & {24{32'(addr_r) == 32'(k)}});
                end
            end else begin
                pad_ow = 24'h0;
            end
        end
    end

`ifdef PROJ_MUX_CTRL_RUN_CNT_EN
    logic [15:0] run_cnt_r;

    // RUN-cycle counter: it is cleared when a request is accepted and it saturates at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_r <= 16'd0;
        end else if (accept_s) begin
            run_cnt_r <= 16'd0;
        end else if ((state_r == ST_RUN) && (run_cnt_r != 16'hFFFF)) begin
            run_cnt_r <= run_cnt_r + 16'd1;
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    assign run_cycles = rst ? 16'd0 : run_cnt_r;
`endif

endmodule

// File: tb/tb_proj_mux_ctrl.sv
// Testbench for proj_mux_ctrl. A driver issues one cycle of stimulus at a time.
// For each cycle it pushes the expected outputs, taken from a timeline model, onto a scoreboard queue.
// A separate monitor pops each entry and compares it against the DUT.
module tb_proj_mux_ctrl;
    localparam int N_PROJ   = 8;
    localparam int ADDR_W   = 4;
    localparam int RST_HOLD = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 sel_valid = 1'b0;
    logic [ADDR_W-1:0]    sel_addr = '0;
    logic                 sel_ready;
    logic [17:0]          pad_iw = '0;
    logic [23:0]          pad_ow;
    logic [N_PROJ-1:0]    proj_ena;
    logic [17:0]          proj_iw;
    logic [24*N_PROJ-1:0] proj_ow = '0;
    logic [ADDR_W-1:0]    active_addr;
    logic                 running;
`ifdef PROJ_MUX_CTRL_RUN_CNT_EN
    logic [15:0]          run_cycles;
`endif

    proj_mux_ctrl #(.N_PROJ(N_PROJ), .ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_addr(sel_addr),
        .sel_ready(sel_ready), .pad_iw(pad_iw), .pad_ow(pad_ow),
        .proj_ena(proj_ena), .proj_iw(proj_iw), .proj_ow(proj_ow),
        .active_addr(active_addr), .running(running)
`ifdef PROJ_MUX_CTRL_RUN_CNT_EN
        , .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel_ready;
        logic [7:0]  ena;
        logic [23:0] pad;
        logic        run;
        logic [3:0]  aa;
        logic [17:0] iw;
        logic [15:0] rc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    // Timeline model. A switch is described by the target index and the cycles elapsed since its acceptance.
    // Age 1 is the single dead cycle. Ages 2..RST_HOLD+1 hold the project in reset.
    // From age RST_HOLD+2 the project runs. An out-of-range target switches everything off after the dead cycle.
    bit m_active = 1'b0;
    int m_tgt    = 0;
    int m_age    = 0;
    int m_last   = 0;
    int m_rc     = 0;

    // Returns the phase: 0 = off, 1 = dead cycle, 2 = held in reset, 3 = running.
    function automatic int phase_of();
        if (!m_active) return 0;
        if (m_age <= 1) return 1;
        if (m_tgt >= N_PROJ) return 0;
        if (m_age <= RST_HOLD + 1) return 2;
        return 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit v, input int a);
        exp_t e;
        int   ph;
        bit   acc;
        @(negedge clk);
        rst       = r;
        sel_valid = v;
        sel_addr  = a[3:0];
        pad_iw    = 18'($urandom);
        for (int i = 0; i < N_PROJ * 24 / 32; i++) proj_ow[i*32 +: 32] = $urandom;
        ph = phase_of();
        if (r) begin
            e.sel_ready = 1'b1; e.ena = 8'h0; e.pad = 24'h0; e.run = 1'b0;
            e.aa = 4'h0; e.iw = pad_iw; e.rc = 16'h0;
        end else begin
            e.sel_ready = (ph == 0) || (ph == 3);
            e.ena       = (ph >= 2) ? 8'(1 << m_tgt) : 8'h0;
            e.pad       = (ph == 3) ? proj_ow[m_tgt*24 +: 24] : 24'h0;
            e.run       = (ph == 3);
            e.aa        = 4'(m_last);
            e.iw        = pad_iw;
            if (ph == 2) e.iw[1] = 1'b0;
            e.rc        = 16'(m_rc);
        end
        sb_q.push_back(e);
        n_pushed++;
        @(posedge clk);
        acc = !r && v && ((ph == 0) || (ph == 3));
        if (r) begin
            m_active = 1'b0; m_last = 0; m_age = 0; m_rc = 0;
        end else if (acc) begin
            m_active = 1'b1; m_tgt = a; m_last = a; m_age = 1; m_rc = 0;
        end else begin
            if ((ph == 3) && (m_rc < 65535)) m_rc++;
            if (m_active) begin
                if (m_age < 1000000) m_age++;
                if ((m_tgt >= N_PROJ) && (m_age >= 2)) m_active = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, int'($urandom_range(0, 15)));
    endtask

    // Monitor: after every falling edge, compare the DUT outputs against the queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_popped++;
                chk("sel_ready",   32'(sel_ready),   32'(e.sel_ready));
                chk("proj_ena",    32'(proj_ena),    32'(e.ena));
                chk("pad_ow",      32'(pad_ow),      32'(e.pad));
                chk("running",     32'(running),     32'(e.run));
                chk("active_addr", 32'(active_addr), 32'(e.aa));
                chk("proj_iw",     32'(proj_iw),     32'(e.iw));
                chk("ena_onehot0", 32'($countones(proj_ena) <= 1), 32'd1);
`ifdef PROJ_MUX_CTRL_RUN_CNT_EN
                chk("run_cycles",  32'(run_cycles),  32'(e.rc));
`endif
            end
        end
    end

    initial begin
        int a;
        // reset
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0);
        // switch to project 3: dead cycle, RST_HOLD held cycles, then run
        drive(1'b0, 1'b1, 3); idle(8);
        // switch 3 -> 5: break before make
        drive(1'b0, 1'b1, 5); idle(7);
        // out-of-range index: the dead cycle, then everything off
        drive(1'b0, 1'b1, 9); idle(3);
        // requests during the dead cycle and HOLD are dropped
        drive(1'b0, 1'b1, 2); drive(1'b0, 1'b1, 6); drive(1'b0, 1'b1, 6);
        idle(1); drive(1'b0, 1'b1, 7); idle(4);
        // reset asserted in the second HOLD cycle
        drive(1'b0, 1'b1, 4); idle(2); drive(1'b1, 1'b0, 0); idle(2);
`ifdef PROJ_MUX_CTRL_RUN_CNT_EN
        // long RUN: the counter saturates, then a new request clears it
        drive(1'b0, 1'b1, 1); idle(70010); drive(1'b0, 1'b1, 2); idle(2);
`endif
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, a);
        end
        idle(1);
        @(negedge clk);
        #4;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("sb_count", 32'(n_popped), 32'(n_pushed));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/proj_mux_ctrl.md
PROJ_MUX_CTRL -- requirements
Module: proj_mux_ctrl

Interface
REQ-001 SHALL have parameter N_PROJ, default 8: number of wrapped projects, 2..16.
REQ-002 SHALL have parameter ADDR_W, default 4: select address width, with 2**ADDR_W >= N_PROJ.
REQ-003 SHALL have parameter RST_HOLD, default 4: cycles project rst_n is held low after a switch, 1..255.
REQ-004 SHALL have port clk, input, 1: single clock for all state.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port sel_valid, input, 1: switch request.
REQ-007 SHALL have port sel_addr, input, ADDR_W: requested project index.
REQ-008 SHALL have port sel_ready, output, 1: request accepted when sel_valid & sel_ready at a rising clk.
REQ-009 SHALL have port pad_iw, input, 18: pad bundle {uio_in[7:0], ui_in[7:0], rst_n, clk}.
REQ-010 SHALL have port pad_ow, output, 24: pad bundle {uio_oe, uio_out, uo_out}.
REQ-011 SHALL have port proj_ena, output, N_PROJ: one-hot or zero project enable.
REQ-012 SHALL have port proj_iw, output, 18: bundle broadcast to all wrappers.
REQ-013 SHALL have port proj_ow, input, 24*N_PROJ: wrapper outputs, project k at bits [24k+23:24k].
REQ-014 SHALL have port active_addr, output, ADDR_W: index of the project being enabled.
REQ-015 SHALL have port running, output, 1: high only in state RUN.

Function
REQ-016 SHALL implement states OFF, DRAIN, HOLD, RUN.
REQ-017 SHALL drive sel_ready high in OFF and RUN, and low in DRAIN and HOLD.
REQ-018 SHALL, on an accepted request in OFF or RUN, latch sel_addr into active_addr and enter DRAIN.
REQ-019 SHALL hold DRAIN exactly one cycle with proj_ena all zero (break-before-make), then enter HOLD if active_addr < N_PROJ, else OFF.
REQ-020 SHALL, in HOLD, assert proj_ena[active_addr], force proj_iw[1] to 0 for RST_HOLD cycles, then enter RUN.
REQ-021 SHALL, in RUN, keep proj_ena[active_addr] asserted and pass proj_iw = pad_iw unmodified.
REQ-022 SHALL pass proj_iw[0] = pad_iw[0] and proj_iw[17:2] = pad_iw[17:2] combinationally in every state.
REQ-023 SHALL drive pad_ow = proj_ow slice [active_addr] combinationally in RUN, and 24'h0 in OFF, DRAIN and HOLD, so uio_oe is never driven outside RUN.
REQ-024 SHALL treat an accepted request for the currently running index as a re-reset via DRAIN and HOLD.
REQ-025 SHALL ignore sel_valid while sel_ready is low; the request is not queued.
REQ-026 SHALL size the HOLD counter to 8 bits and reload it on every HOLD entry.

Reset
REQ-027 SHALL, while rst is high, force state OFF, active_addr 0, HOLD counter 0, and sel_ready 1 as an OFF-state output.
REQ-028 SHALL give every output its OFF value during reset: proj_ena 0, pad_ow 0, running 0, proj_iw[1] = pad_iw[1].
REQ-029 SHALL, on reset asserted in any state, including mid-HOLD, reach OFF on the next clk edge with no partial enable.

Configuration
REQ-030 SHALL, when macro PROJ_MUX_CTRL_RUN_CNT_EN is defined, add output run_cycles, 16 bits: cycles spent in RUN since the last RUN entry, saturating at 16'hFFFF, cleared on reset and on DRAIN entry.
REQ-031 SHALL, without PROJ_MUX_CTRL_RUN_CNT_EN, omit the run_cycles port and counter, with all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, then sel_addr=3 accepted at cycle 0 -> DRAIN at cycle 1, proj_ena=8'h08 with proj_iw[1]=0 at cycles 2..5, running=1 with pad_ow=proj_ow slice 3 from cycle 6.
REQ-033 SHALL cover: in RUN on project 3, a request for 5 -> one cycle with proj_ena=0 and pad_ow=0, then proj_ena=8'h20, and proj_ena never 8'h28.
REQ-034 SHALL cover: sel_addr=9 with N_PROJ=8 -> DRAIN then OFF, proj_ena=0, pad_ow=0, sel_ready=1.
REQ-035 SHALL cover: sel_valid pulsed during HOLD -> sel_ready=0, request dropped, original project reaches RUN.
REQ-036 SHALL cover: rst asserted at the 2nd HOLD cycle -> next edge OFF, proj_ena=0, active_addr=0.
REQ-037 SHALL cover, with PROJ_MUX_CTRL_RUN_CNT_EN defined: 70000 cycles in RUN -> run_cycles=16'hFFFF, and a new request clears it to 0 on DRAIN entry.
